// File: rtl/la_sdemux4.sv
// ---------------------------------------------------------------------------
// la_sdemux4 -- 1-to-4 streaming demultiplexer (inverse of the 4-input mux).
//
// One valid/ready producer is steered to one of four consumers. A single
// entry register holds the outgoing beat. The destination is taken from
// in_sel on the first beat of a packet and locked until the in_last beat.
//
// Parameters:
//   DW    payload width in bits (>= 1)
//   PROP  cell-library implementation property, no functional effect
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   in_data    input payload
//   in_last    final beat of packet
//   in_sel     destination channel {s1,s0}, used on the first beat only
//   out_valid  per-channel valid, one-hot or zero
//   out_ready  per-channel ready
//   out_data   payload of the held beat, shared by all channels
//   out_last   last flag of the held beat
//   busy       packet in progress or register full
// ---------------------------------------------------------------------------
module la_sdemux4 #(
    parameter int    DW   = 8,
    parameter string PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic [1:0]    in_sel,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    // PROP only selects a library implementation; the behaviour is identical.
    if (PROP != "DEFAULT") begin : g_prop_custom
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    lock_sel;
    logic          vld_p1;
    logic [DW-1:0] data_p1;
    logic          last_p1;
    logic [1:0]    sel_p1;

    logic          accept;
    logic          drain;
    logic [1:0]    eff_sel;

    // Combinational ready through the selected channel keeps one beat per
    // cycle; ready of the other channels never matters.
    assign in_ready = ~vld_p1 | out_ready[sel_p1];
    assign accept   = in_valid & in_ready;
    assign drain    = vld_p1 & out_ready[sel_p1];
    assign eff_sel  = (state == ST_LOCK) ? lock_sel : in_sel;

    assign out_valid = vld_p1 ? (4'b0001 << sel_p1) : 4'b0000;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign busy      = vld_p1 | (state == ST_LOCK);

    // ---- stage p0 -> p1: input accept into the holding register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            sel_p1  <= 2'd0;
        end else if (accept) begin
            // Reload also covers a simultaneous drain, so no bubble appears.
            vld_p1  <= 1'b1;
            data_p1 <= in_data;
            last_p1 <= in_last;
            sel_p1  <= eff_sel;
        end else if (drain) begin
            vld_p1  <= 1'b0;
        end
    end

    // Packet lock: the channel chosen by the first beat holds until in_last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lock_sel <= 2'd0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!in_last) begin
                        state    <= ST_LOCK;
                        lock_sel <= in_sel;
                    end
                end
                ST_LOCK: begin
                    if (in_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_la_sdemux4.sv
module tb_la_sdemux4;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int errors = 0;
    int checks = 0;

    la_sdemux4 #(.DW(DW), .PROP("DEFAULT")) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1-2 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'hFF; in_last = 1'b1;
        in_sel = 2'd3; out_ready = 4'hF;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b want=0000", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single_beat();
        logic [3:0] exp_v;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = 8'hA0 + 8'(i); in_last = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d] got=%b want=1", i, in_ready); end
            cyc();
            exp_v = 4'b0001 << i;
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL single_out_valid[%0d] got=%b want=%b", i, out_valid, exp_v); end
            checks++; if (out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL single_out_data[%0d] got=%h want=%h", i, out_data, 8'hA0 + 8'(i)); end
            checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_out_last[%0d] got=%b want=1", i, out_last); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got=%b want=0000", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b want=0", busy); end
    endtask

    task automatic test_lock();
        logic [1:0] sels [4];
        sels[0] = 2'd2; sels[1] = 2'd1; sels[2] = 2'd3; sels[3] = 2'd0;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = sels[k]; in_data = 8'hB0 + 8'(k); in_last = (k == 3);
            cyc();
            checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL lock_out_valid[%0d] got=%b want=0100", k, out_valid); end
            checks++; if (out_data !== 8'hB0 + 8'(k)) begin errors++; $display("FAIL lock_out_data[%0d] got=%h want=%h", k, out_data, 8'hB0 + 8'(k)); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL lock_out_last[%0d] got=%b want=%b", k, out_last, (k == 3)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy[%0d] got=%b want=1", k, busy); end
        end
        in_valid = 1'b0; in_sel = 2'd0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_busy_after got=%b want=0", busy); end
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL lock_drain got=%b want=0000", out_valid); end
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hC0; in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL lock_next_pkt got=%b want=0010", out_valid); end
        checks++; if (out_data !== 8'hC0) begin errors++; $display("FAIL lock_next_data got=%h want=C0", out_data); end
        cyc();
    endtask

    task automatic test_back_pressure();
        out_ready = 4'b0111;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hD0; in_last = 1'b1;
        cyc();
        in_data = 8'hD1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
            checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b want=1000", c, out_valid); end
            checks++; if (out_data !== 8'hD0) begin errors++; $display("FAIL bp_out_data[%0d] got=%h want=D0", c, out_data); end
            cyc();
        end
        out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        checks++; if (out_data !== 8'hD0) begin errors++; $display("FAIL bp_first_beat got=%h want=D0", out_data); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL bp_second_valid got=%b want=1000", out_valid); end
        checks++; if (out_data !== 8'hD1) begin errors++; $display("FAIL bp_second_data got=%h want=D1", out_data); end
        cyc();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got=%b want=0000", out_valid); end
    endtask

    task automatic test_streaming();
        int accepts = 0;
        out_ready = 4'hF;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h10 + 8'(i); in_last = (i == 15);
            #1;
            if (in_ready === 1'b1) accepts++;
            cyc();
            checks++; if (out_valid !== 4'b0001 || out_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL stream_beat[%0d] got=%b/%h want=0001/%h", i, out_valid, out_data, 8'h10 + 8'(i));
            end
        end
        checks++; if (accepts !== 16) begin errors++; $display("FAIL stream_accepts got=%0d want=16", accepts); end
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stream_drain got=%b want=0000", out_valid); end
    endtask

    task automatic test_reset_midpacket();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hE0; in_last = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b/%b want=0010/1", out_valid, busy); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_out_valid got=%b want=0000", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data got=%h want=00", out_data); end
        out_ready = 4'hF;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hE1; in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mid_next_route got=%b want=1000", out_valid); end
        cyc();
    endtask

    task automatic test_idle_noise();
        out_ready = 4'hF;
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_sel = 2'($urandom_range(0, 3)); in_data = 8'($urandom); in_last = 1'($urandom);
            cyc();
            checks++; if (out_valid !== 4'b0000 || busy !== 1'b0 || out_data !== 8'hE1) begin
                errors++; $display("FAIL idle_noise[%0d] got=%b/%b/%h want=0000/0/E1", c, out_valid, busy, out_data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_lock();
        test_back_pressure();
        test_streaming();
        test_reset_midpacket();
        test_idle_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
